// File: rtl/a_reg_scheduler_pkg.sv
// Shared constants for the A-register write-port scheduler: file geometry
// and the fixed index assignment of the result sources on the write port.
package a_reg_scheduler_pkg;

    localparam int A_WIDTH    = 24;
    localparam int A_DEPTH    = 8;
    localparam int A_LOGDEPTH = 3;
    localparam int A_NREQ     = 4;

    // Result sources, in arbiter request-bit order
    localparam int SRC_AADD = 0;
    localparam int SRC_AMUL = 1;
    localparam int SRC_MEM  = 2;
    localparam int SRC_S2A  = 3;

endpackage

// File: rtl/a_reg_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the rotating
// pointer (with wrap-around) and moves the pointer just past the winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] gidx;
    logic [PW-1:0] idx;
    logic          found;

    // Search upward from the pointer for the first active request
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr_q) + i) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gidx     = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    // Pointer advances past the winner; it holds when nobody asks
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/a_reg_scheduler.sv
// A-register file scheduler: per-register reservation bits for issue
// interlocks (RAW and WAW), plus the registered, arbitrated write port.
module a_reg_scheduler
    import a_reg_scheduler_pkg::*;
#(
    parameter int WIDTH    = A_WIDTH,
    parameter int DEPTH    = A_DEPTH,
    parameter int LOGDEPTH = A_LOGDEPTH,
    parameter int NREQ     = A_NREQ
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_issue_vld,
    input  logic                     i_issue_wr,
    input  logic [LOGDEPTH-1:0]      i_issue_dst,
    input  logic                     i_issue_rd_j,
    input  logic [LOGDEPTH-1:0]      i_issue_j,
    input  logic                     i_issue_rd_k,
    input  logic [LOGDEPTH-1:0]      i_issue_k,
    output logic                     o_issue_ok,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*LOGDEPTH-1:0] i_req_addr,
    input  logic [NREQ*WIDTH-1:0]    i_req_data,
    output logic [NREQ-1:0]          o_gnt,
    output logic                     o_wr_en,
    output logic [LOGDEPTH-1:0]      o_wr_addr,
    output logic [WIDTH-1:0]         o_wr_data,
    output logic [DEPTH-1:0]         o_resv,
    output logic                     o_busy
);

    function automatic logic [DEPTH-1:0] dec(input logic [LOGDEPTH-1:0] a);
        dec    = '0;
        dec[a] = 1'b1;
    endfunction

    logic [DEPTH-1:0]    resv_q, resv_d, eff_resv;
    logic                wr_en_q, wr_en_d;
    logic [LOGDEPTH-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [NREQ-1:0]     gnt;
    logic                conflict;
    logic                issue_ok;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (i_req),
        .gnt (gnt)
    );

    // The register retiring this cycle is bypassed by the file, so treat it as free
    always_comb begin
        eff_resv = resv_q;
        if (wr_en_q) begin
            eff_resv = resv_q & ~dec(wr_addr_q);
        end
    end

    // Interlock check; register 0 is a constant on reads but still WAW-held on writes
    always_comb begin
        conflict = 1'b0;
        if (i_issue_rd_j && (i_issue_j != '0) && eff_resv[i_issue_j]) conflict = 1'b1;
        if (i_issue_rd_k && (i_issue_k != '0) && eff_resv[i_issue_k]) conflict = 1'b1;
        if (i_issue_wr && eff_resv[i_issue_dst])                      conflict = 1'b1;
        issue_ok = i_issue_vld && !conflict;
        resv_d   = eff_resv | ((issue_ok && i_issue_wr) ? dec(i_issue_dst) : '0);
    end

    // Select the granted source's address and data for the write stage
    always_comb begin
        wr_en_d   = |gnt;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        for (int n = 0; n < NREQ; n++) begin
            if (gnt[n]) begin
                wr_addr_d = i_req_addr[n*LOGDEPTH +: LOGDEPTH];
                wr_data_d = i_req_data[n*WIDTH +: WIDTH];
            end
        end
    end

    // Reservation bitmap and write-stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            resv_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            resv_q    <= resv_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_issue_ok = issue_ok;
    assign o_gnt      = gnt;
    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_resv     = resv_q;
    assign o_busy     = |resv_q;

endmodule

// File: tb/tb_a_reg_scheduler.sv
// Scoreboard bench for a_reg_scheduler: a behavioural model predicts issue
// acceptance, grants and reservations each cycle; every grant pushes the
// expected register-file write, which a negedge monitor pops and compares.
module tb_a_reg_scheduler;
    import a_reg_scheduler_pkg::*;

    localparam int W = A_WIDTH;
    localparam int D = A_DEPTH;
    localparam int L = A_LOGDEPTH;
    localparam int N = A_NREQ;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_issue_vld = 0, i_issue_wr = 0, i_issue_rd_j = 0, i_issue_rd_k = 0;
    logic [L-1:0]   i_issue_dst = '0, i_issue_j = '0, i_issue_k = '0;
    logic           o_issue_ok;
    logic [N-1:0]   i_req = '0;
    logic [N*L-1:0] i_req_addr = '0;
    logic [N*W-1:0] i_req_data = '0;
    logic [N-1:0]   o_gnt;
    logic           o_wr_en;
    logic [L-1:0]   o_wr_addr;
    logic [W-1:0]   o_wr_data;
    logic [D-1:0]   o_resv;
    logic           o_busy;

    always #5 clk = ~clk;

    a_reg_scheduler dut (
        .clk(clk), .rst(rst),
        .i_issue_vld(i_issue_vld), .i_issue_wr(i_issue_wr), .i_issue_dst(i_issue_dst),
        .i_issue_rd_j(i_issue_rd_j), .i_issue_j(i_issue_j),
        .i_issue_rd_k(i_issue_rd_k), .i_issue_k(i_issue_k),
        .o_issue_ok(o_issue_ok),
        .i_req(i_req), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .o_gnt(o_gnt), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_resv(o_resv), .o_busy(o_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected register-file writes, {addr, data}
    logic [L+W-1:0] exp_q[$];

    // Requester state
    logic [N-1:0] req_v = '0;
    logic [N-1:0] cool  = '0;
    logic [L-1:0] req_a[N];
    logic [W-1:0] req_d[N];

    // Reference model state
    logic [D-1:0] m_resv  = '0;
    logic         m_wen   = 1'b0;
    logic [L-1:0] m_waddr = '0;
    int           m_ptr   = 0;

    // Combinational outputs seen in the last cycle
    logic         seen_ok;
    logic [N-1:0] seen_gnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic set_issue(input logic vld, input logic wr, input logic [L-1:0] dst,
                             input logic rdj, input logic [L-1:0] j,
                             input logic rdk, input logic [L-1:0] k);
        i_issue_vld = vld; i_issue_wr = wr; i_issue_dst = dst;
        i_issue_rd_j = rdj; i_issue_j = j; i_issue_rd_k = rdk; i_issue_k = k;
    endtask

    task automatic drive();
        for (int n = 0; n < N; n++) begin
            i_req[n]            = req_v[n];
            i_req_addr[n*L +: L] = req_a[n];
            i_req_data[n*W +: W] = req_d[n];
        end
    endtask

    task automatic add_req(input int n, input logic [L-1:0] a, input logic [W-1:0] d);
        req_v[n] = 1'b1;
        req_a[n] = a;
        req_d[n] = d;
    endtask

    // One clock cycle: compare against the model, advance the model, cross the edge
    task automatic tick();
        logic [D-1:0] eff;
        logic         conf, ok;
        int           g;
        logic [N-1:0] eg;
        #2;
        eff = m_resv;
        if (m_wen) eff[m_waddr] = 1'b0;
        conf = (i_issue_rd_j && i_issue_j != 0 && eff[i_issue_j]) ||
               (i_issue_rd_k && i_issue_k != 0 && eff[i_issue_k]) ||
               (i_issue_wr && eff[i_issue_dst]);
        ok = i_issue_vld && !conf;
        g = -1;
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (g < 0 && req_v[c]) g = c;
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("issue_ok", 32'(o_issue_ok), 32'(ok));
        chk("gnt", 32'(o_gnt), 32'(eg));
        chk("resv", 32'(o_resv), 32'(m_resv));
        chk("busy", 32'(o_busy), 32'(|m_resv));
        chk("wr_en", 32'(o_wr_en), 32'(m_wen));
        seen_ok  = o_issue_ok;
        seen_gnt = o_gnt;
        if (rst) begin
            m_resv = '0; m_wen = 1'b0; m_waddr = '0; m_ptr = 0;
            req_v = '0; cool = '0;
        end else begin
            m_resv = eff;
            if (ok && i_issue_wr) m_resv[i_issue_dst] = 1'b1;
            if (g >= 0) begin
                exp_q.push_back({req_a[g], req_d[g]});
                m_wen   = 1'b1;
                m_waddr = req_a[g];
                m_ptr   = (g + 1) % N;
                req_v[g] = 1'b0;
                cool[g]  = 1'b1;
            end else begin
                m_wen = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    // Write-port monitor
    always @(negedge clk) begin
        if (o_wr_en === 1'b1) begin
            logic [L+W-1:0] e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", o_wr_addr, o_wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr_data", 32'({o_wr_addr, o_wr_data}), 32'(e));
            end
        end
    end

    initial begin
        for (int n = 0; n < N; n++) begin
            req_a[n] = '0;
            req_d[n] = '0;
        end
        drive();
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        chk("rst_resv", 32'(o_resv), 32'h0);
        chk("rst_wr_en", 32'(o_wr_en), 32'h0);
        chk("rst_wr_addr", 32'(o_wr_addr), 32'h0);
        chk("rst_wr_data", 32'(o_wr_data), 32'h0);

        // Reserve r3, then a RAW hold on j=3 until the write-back cycle
        set_issue(1, 1, 3, 0, 0, 0, 0); tick();
        chk("issue_dst3", 32'(seen_ok), 32'h1);
        chk("resv_08", 32'(o_resv), 32'h08);
        set_issue(1, 0, 0, 1, 3, 0, 0); tick();
        chk("raw_hold_j", 32'(seen_ok), 32'h0);
        add_req(SRC_MEM, 3'd3, 24'h00ABCD); drive(); tick();
        chk("gnt_src2", 32'(seen_gnt), 32'b0100);
        chk("raw_hold_gnt_cycle", 32'(seen_ok), 32'h0);
        chk("wb_en", 32'(o_wr_en), 32'h1);
        chk("wb_addr", 32'(o_wr_addr), 32'h3);
        chk("wb_data", 32'(o_wr_data), 32'h00ABCD);
        set_issue(1, 0, 0, 0, 0, 1, 3); tick();
        chk("bypass_k3", 32'(seen_ok), 32'h1);
        chk("resv_clear", 32'(o_resv), 32'h0);
        set_issue(0, 0, 0, 0, 0, 0, 0);

        // All four sources at once from rr_ptr=0
        rst = 1'b1; tick(); rst = 1'b0;
        for (int n = 0; n < N; n++) add_req(n, L'(n + 1), W'(32'h100 + n));
        drive();
        for (int i = 0; i < N; i++) begin
            tick();
            chk("rr_all_gnt", 32'(seen_gnt), 32'(1 << i));
            chk("rr_all_wr_en", 32'(o_wr_en), 32'h1);
        end
        tick();
        chk("rr_idle_wr_en", 32'(o_wr_en), 32'h0);
        add_req(SRC_AADD, 3'd6, 24'h111111);
        add_req(SRC_S2A, 3'd7, 24'h333333);
        drive(); tick();
        chk("rr_1001_first", 32'(seen_gnt), 32'b0001);
        tick();
        chk("rr_1001_second", 32'(seen_gnt), 32'b1000);
        tick();

        // Register 0: reads never conflict, writes are WAW-held
        set_issue(1, 1, 0, 0, 0, 0, 0); tick();
        chk("resv_01", 32'(o_resv), 32'h01);
        set_issue(1, 0, 0, 1, 0, 1, 0); tick();
        chk("r0_read_ok", 32'(seen_ok), 32'h1);
        set_issue(1, 1, 0, 0, 0, 0, 0); tick();
        chk("r0_waw_hold", 32'(seen_ok), 32'h0);
        set_issue(0, 0, 0, 0, 0, 0, 0);
        add_req(SRC_AADD, 3'd0, 24'h000000); drive(); tick(); tick();
        chk("r0_cleared", 32'(o_resv), 32'h0);

        // Set wins over clear on the same register
        set_issue(1, 1, 5, 0, 0, 0, 0); tick();
        set_issue(0, 0, 0, 0, 0, 0, 0);
        add_req(SRC_AMUL, 3'd5, 24'h0F0F0F); drive(); tick();
        set_issue(1, 1, 5, 0, 0, 0, 0); tick();
        chk("set_wins_ok", 32'(seen_ok), 32'h1);
        chk("set_wins_bit", 32'(o_resv[5]), 32'h1);
        set_issue(0, 0, 0, 0, 0, 0, 0); tick();

        // Fill the bitmap, then reset with a request pending
        for (int d = 0; d < D; d++) begin
            set_issue(1, 1, L'(d), 0, 0, 0, 0); tick();
        end
        set_issue(0, 0, 0, 0, 0, 0, 0);
        chk("resv_ff", 32'(o_resv), 32'hFF);
        add_req(SRC_S2A, 3'd2, 24'h222222); drive();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_resv", 32'(o_resv), 32'h0);
        chk("mid_rst_wr_en", 32'(o_wr_en), 32'h0);
        chk("mid_rst_busy", 32'(o_busy), 32'h0);
        add_req(SRC_AADD, 3'd1, 24'h0000AA);
        add_req(SRC_S2A, 3'd4, 24'h0000BB);
        drive(); tick();
        chk("ptr_after_rst", 32'(seen_gnt), 32'b0001);
        tick(); tick();

        // Randomized traffic
        cool = '0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            set_issue(($urandom_range(0, 9) < 8), 1'($urandom), L'($urandom),
                      1'($urandom), L'($urandom), 1'($urandom), L'($urandom));
            for (int n = 0; n < N; n++) begin
                if (cool[n]) cool[n] = 1'b0;
                else if (!req_v[n] && $urandom_range(0, 9) < 4)
                    add_req(n, L'($urandom), W'($urandom));
            end
            drive();
            tick();
        end
        rst = 1'b0;
        set_issue(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++) tick();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
